// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_resp data-memory responder: bus widths,
// FSM state encoding and the address-legality helper.
package dmem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Encodings are kept as plain constants so older code that compares raw
    // state bits still lines up with the enum below.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        WAIT = S_WAIT,
        RESP = S_RESP
    } dmem_state_e;

    // An access is illegal when it is not word aligned or it falls beyond
    // the last storage word (byte address >= 4 * 2**idx_w).
    function automatic logic addr_is_bad(input logic [ADDR_W-1:0] addr,
                                         input int idx_w);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> (idx_w + 2)) != '0);
        return misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous storage with a byte-enabled write port and a
// registered read port. Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes and a read that lands in the output register one edge later.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one request at a time, waits WAIT_CYCLES
// clocks, performs the storage access on entry to the response state and
// holds the response until the initiator takes it.
// Optional build macro DMEM_RESP_PERF_EN adds saturating read/write
// completion counters (o_rd_count, o_wr_count).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [BE_W-1:0]   i_req_be,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err
`ifdef DMEM_RESP_PERF_EN
    ,
    output logic [15:0]       o_rd_count,
    output logic [15:0]       o_wr_count
`endif
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state_q;
    dmem_state_e state_d;
    logic [3:0]  cnt_q;

    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [BE_W-1:0]   req_be_q;
    logic              rsp_err_q;

    logic              accept;
    logic              enter_resp;
    logic              rsp_hs;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_err;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_rdata;

    // Ready only while idle, and forced low for the whole reset cycle.
    always_comb begin
        o_req_ready = (state_q == IDLE) && !i_reset;
        accept      = i_req_valid && o_req_ready;
    end

    // Next-state selection for the IDLE -> WAIT -> RESP -> IDLE loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the acceptance edge, so the
    // live request fields are used while idle and the captured ones otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = i_req_we;
            acc_addr  = i_req_addr;
            acc_wdata = i_req_wdata;
            acc_be    = i_req_be;
        end else begin
            acc_we    = req_we_q;
            acc_addr  = req_addr_q;
            acc_wdata = req_wdata_q;
            acc_be    = req_be_q;
        end
        acc_err    = addr_is_bad(acc_addr, IDX_W);
        enter_resp = (state_d == RESP) && (state_q != RESP) && !i_reset;
        arr_we     = enter_resp && acc_we && !acc_err;
        arr_re     = enter_resp && !acc_we && !acc_err;
    end

    // Control state: FSM, wait counter and the latched error flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && (WAIT_CYCLES > 0)) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp) begin
                rsp_err_q <= acc_err;
            end
        end
    end

    // Request fields captured at acceptance; datapath only, no reset needed.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_we_q    <= i_req_we;
            req_addr_q  <= i_req_addr;
            req_wdata_q <= i_req_wdata;
            req_be_q    <= i_req_be;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (i_clk),
        .we    (arr_we),
        .be    (acc_be),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .re    (arr_re),
        .rdata (arr_rdata)
    );

    // Response outputs are qualified by the RESP state so they read 0 elsewhere.
    always_comb begin
        o_rsp_valid = (state_q == RESP);
        o_rsp_err   = o_rsp_valid && rsp_err_q;
        if (o_rsp_valid && !req_we_q && !rsp_err_q) begin
            o_rsp_rdata = arr_rdata;
        end else begin
            o_rsp_rdata = '0;
        end
        rsp_hs = o_rsp_valid && i_rsp_ready && !i_reset;
    end

`ifdef DMEM_RESP_PERF_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    // Count completed good handshakes, sticking at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (rsp_hs && !rsp_err_q) begin
            if (!req_we_q && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (req_we_q && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign o_rd_count = rd_cnt_q;
    assign o_wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp (DEPTH_WORDS=256, WAIT_CYCLES=2): a vector
// table of single transactions plus hand-written hold and reset sequences.
module tb_dmem_resp;

    logic        i_clk;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_be;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
`ifdef DMEM_RESP_PERF_EN
    logic [15:0] o_rd_count;
    logic [15:0] o_wr_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_resp #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(2)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_be    (i_req_be),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err)
`ifdef DMEM_RESP_PERF_EN
        ,
        .o_rd_count  (o_rd_count),
        .o_wr_count  (o_wr_count)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic [31:0] exp_rdata,
                           input logic exp_err);
        vec_t v;
        v = '{we, addr, wdata, be, exp_rdata, exp_err};
        vecs.push_back(v);
    endtask

    // One full transaction: present, accept, measure latency, optionally hold
    // the response for 'hold' cycles checking stability, then hand-shake.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input int hold, output logic [31:0] rdata,
                                  output logic err, output int lat, output logic stable);
        int guard;
        stable      = 1'b1;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_be    = be;
        i_rsp_ready = 1'b0;
        guard = 0;
        while (o_req_ready !== 1'b1 && guard < 50) begin
            @(posedge i_clk); #1;
            guard++;
        end
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        lat = 1;
        while (o_rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge i_clk); #1;
            lat++;
        end
        if (o_rsp_valid !== 1'b1) begin
            rdata  = 'x;
            err    = 1'bx;
            stable = 1'b0;
            return;
        end
        rdata = o_rsp_rdata;
        err   = o_rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk); #1;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== rdata ||
                o_rsp_err !== err || o_req_ready !== 1'b0) begin
                stable = 1'b0;
            end
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        st;
        int          rd_model;
        int          wr_model;
        int          guard;

        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_req_be    = '0;
        i_rsp_ready = 1'b0;

        add_vec(1'b1, 32'h000, 32'h0BADF00D, 4'hF, 32'h0,        1'b0);
        add_vec(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        add_vec(1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        add_vec(1'b1, 32'h010, 32'h11223344, 4'h5, 32'h0,        1'b0);
        add_vec(1'b0, 32'h010, 32'h0,        4'h0, 32'hDE22BE44, 1'b0);
        add_vec(1'b0, 32'h012, 32'h0,        4'h0, 32'h0,        1'b1);
        add_vec(1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1);
        add_vec(1'b1, 32'h012, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        add_vec(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1);
        add_vec(1'b0, 32'h010, 32'h0,        4'h0, 32'hDE22BE44, 1'b0);
        add_vec(1'b0, 32'h000, 32'h0,        4'h0, 32'h0BADF00D, 1'b0);
        add_vec(1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
        add_vec(1'b0, 32'h3FC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        add_vec(1'b1, 32'h020, 32'h12345678, 4'hF, 32'h0,        1'b0);
        add_vec(1'b1, 32'h020, 32'hA5A5A5A5, 4'h0, 32'h0,        1'b0);
        add_vec(1'b0, 32'h020, 32'h0,        4'h0, 32'h12345678, 1'b0);
        add_vec(1'b1, 32'h014, 32'h00000000, 4'hF, 32'h0,        1'b0);
        add_vec(1'b1, 32'h014, 32'hAABBCCDD, 4'hA, 32'h0,        1'b0);
        add_vec(1'b0, 32'h014, 32'h0,        4'h0, 32'hAA00CC00, 1'b0);

        // Reset values while reset is held, then ready right after release.
        repeat (2) @(posedge i_clk);
        #1;
        check_output("reset req_ready", {31'd0, o_req_ready}, 32'd0);
        check_output("reset rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check_output("reset rsp_rdata", o_rsp_rdata, 32'd0);
        check_output("reset rsp_err",   {31'd0, o_rsp_err},   32'd0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        check_output("post-reset req_ready", {31'd0, o_req_ready}, 32'd1);
        rd_model = 0;
        wr_model = 0;

        // Table-driven single transactions.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0,
                           rd, er, lat, st);
            check_output($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check_output($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            if (!vecs[i].exp_err) begin
                if (vecs[i].we) wr_model++;
                else rd_model++;
            end
        end

`ifdef DMEM_RESP_PERF_EN
        check_output("table rd_count", {16'd0, o_rd_count}, 32'(rd_model));
        check_output("table wr_count", {16'd0, o_wr_count}, 32'(wr_model));
`endif

        // Response held for 5 cycles must stay put and block new requests.
        apply_stimulus(1'b0, 32'h010, 32'h0, 4'h0, 5, rd, er, lat, st);
        check_output("hold rdata",  rd, 32'hDE22BE44);
        check_output("hold stable", {31'd0, st}, 32'd1);
        check_output("hold latency", 32'(lat), 32'd3);
        check_output("hold valid after hs", {31'd0, o_rsp_valid}, 32'd0);
        check_output("hold ready after hs", {31'd0, o_req_ready}, 32'd1);

        // Reset during WAIT of a write must abort it.
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 32'h020;
        i_req_wdata = 32'hFFFFFFFF;
        i_req_be    = 4'hF;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        check_output("wait req_ready", {31'd0, o_req_ready}, 32'd0);
        check_output("wait rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        check_output("abort rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check_output("abort rsp_rdata", o_rsp_rdata, 32'd0);
        check_output("abort rsp_err",   {31'd0, o_rsp_err}, 32'd0);
        check_output("abort req_ready", {31'd0, o_req_ready}, 32'd0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        check_output("abort release ready", {31'd0, o_req_ready}, 32'd1);
        apply_stimulus(1'b0, 32'h020, 32'h0, 4'h0, 0, rd, er, lat, st);
        check_output("abort readback", rd, 32'h12345678);

        // Reset during RESP must discard the pending response.
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h3FC;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        guard = 0;
        while (o_rsp_valid !== 1'b1 && guard < 20) begin
            @(posedge i_clk); #1;
            guard++;
        end
        check_output("resp before reset", o_rsp_rdata, 32'hCAFEF00D);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check_output("resp discard valid", {31'd0, o_rsp_valid}, 32'd0);
        check_output("resp discard rdata", o_rsp_rdata, 32'd0);
        @(posedge i_clk); #1;
        apply_stimulus(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat, st);
        check_output("after discard read", rd, 32'hCAFEF00D);

`ifdef DMEM_RESP_PERF_EN
        // Fresh counters: 3 good reads, 2 good writes, 1 error.
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check_output("perf reset rd", {16'd0, o_rd_count}, 32'd0);
        apply_stimulus(1'b0, 32'h010, 32'h0, 4'h0, 0, rd, er, lat, st);
        apply_stimulus(1'b0, 32'h020, 32'h0, 4'h0, 0, rd, er, lat, st);
        apply_stimulus(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat, st);
        apply_stimulus(1'b1, 32'h040, 32'h1, 4'hF, 0, rd, er, lat, st);
        apply_stimulus(1'b1, 32'h044, 32'h2, 4'hF, 0, rd, er, lat, st);
        apply_stimulus(1'b0, 32'h012, 32'h0, 4'h0, 0, rd, er, lat, st);
        check_output("perf rd_count", {16'd0, o_rd_count}, 32'd3);
        check_output("perf wr_count", {16'd0, o_wr_count}, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit storage words, which must be a power of 2.
REQ-003 Parameter WAIT_CYCLES, default 2, SHALL set the access wait states, range 0..15.
REQ-004 Port i_clk SHALL be an input, 1 bit wide: the block clock.
REQ-005 Port i_reset SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-006 Port i_req_valid SHALL be an input, 1 bit wide: the initiator presents a request.
REQ-007 Port o_req_ready SHALL be an output, 1 bit wide: the responder accepts the request.
REQ-008 Port i_req_we SHALL be an input, 1 bit wide: 1 = write, 0 = read.
REQ-009 Port i_req_addr SHALL be an input, 32 bits wide: byte address.
REQ-010 Port i_req_wdata SHALL be an input, 32 bits wide: write data.
REQ-011 Port i_req_be SHALL be an input, 4 bits wide: byte enables for writes.
REQ-012 Port o_rsp_valid SHALL be an output, 1 bit wide: a response is available.
REQ-013 Port i_rsp_ready SHALL be an input, 1 bit wide: the initiator accepts the response.
REQ-014 Port o_rsp_rdata SHALL be an output, 32 bits wide: read data; it SHALL be 0 for writes and errors.
REQ-015 Port o_rsp_err SHALL be an output, 1 bit wide: the access was misaligned or out of range.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP; o_req_ready=1 only in IDLE.
REQ-017 A request SHALL be accepted on the cycle where i_req_valid and o_req_ready are both 1; addr, we, wdata and be SHALL be registered at acceptance.
REQ-018 On acceptance, the FSM SHALL go IDLE->WAIT if WAIT_CYCLES>0, or IDLE->RESP if WAIT_CYCLES=0.
REQ-019 In WAIT, a 4-bit counter SHALL load WAIT_CYCLES-1 and decrement; WAIT->RESP when the counter is 0.
REQ-020 The request-to-o_rsp_valid latency SHALL be WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 The storage access SHALL occur on the transition into RESP: a write updates only the bytes whose be bit is 1, and a read captures the word into o_rsp_rdata.
REQ-022 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-023 An error SHALL be flagged when addr[1:0]!=0 or addr>=4*DEPTH_WORDS: o_rsp_err=1, storage is untouched, and rdata=0.
REQ-024 A write with be=4'b0000 SHALL be a legal no-op write with err=0.
REQ-025 In RESP, o_rsp_valid, o_rsp_rdata and o_rsp_err SHALL be held stable until i_rsp_ready=1, then the FSM goes RESP->IDLE and o_rsp_valid drops on the next cycle.
REQ-026 There SHALL be no back-to-back acceptance: a new request can be accepted no earlier than the cycle after RESP exits, so the minimum period is WAIT_CYCLES+2 cycles.
REQ-027 i_req_valid while not ready SHALL be ignored, and the initiator must hold the request.
REQ-028 i_rsp_ready outside RESP SHALL be ignored.

Reset
REQ-029 When i_reset=1 at the clock edge, the state SHALL be IDLE, the counter 0, o_rsp_valid=0, o_rsp_rdata=0, and o_rsp_err=0.
REQ-030 o_req_ready SHALL be 0 while i_reset=1, and 1 on the first cycle after release.
REQ-031 Reset SHALL NOT clear the storage contents.
REQ-032 Reset during WAIT SHALL abort the access with no write performed; reset during RESP SHALL discard the response.

Configuration
REQ-033 Macro DMEM_RESP_PERF_EN SHALL control the performance counters.
REQ-034 When DMEM_RESP_PERF_EN is defined, the outputs o_rd_count[15:0] and o_wr_count[15:0] SHALL exist.
REQ-035 These counters SHALL increment on each completed non-error read or write response handshake, saturate at 16'hFFFF, and reset to 0.
REQ-036 When DMEM_RESP_PERF_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 Package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the address and data width constants (32), and the byte-enable width (4).
REQ-038 Sub-module dmem_array SHALL be the synchronous word storage with a byte-enable write port and a registered read; it has no reset.

Verification
REQ-039 Scenario: WAIT_CYCLES=2, write addr 0x10 data 0xDEADBEEF be 4'hF, then read 0x10 -> each o_rsp_valid arrives 3 cycles after acceptance; read rdata=0xDEADBEEF; err=0.
REQ-040 Scenario: write 0x10 data 0x11223344 be 4'b0101 over 0xDEADBEEF, then read -> rdata=0xDE22BE44.
REQ-041 Scenario: read addr 0x12 (misaligned), and separately read 0x400 with DEPTH_WORDS=256 -> err=1, rdata=0, memory unchanged.
REQ-042 Scenario: hold i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid and rdata stay stable, o_req_ready=0 throughout, and a new request is accepted only after the handshake.
REQ-043 Scenario: assert i_reset during WAIT of a write to 0x20 -> a following read of 0x20 returns the old value, and the outputs are 0 the cycle after reset.
REQ-044 Scenario: with DMEM_RESP_PERF_EN, do 3 reads, 2 writes and 1 error -> o_rd_count=3, o_wr_count=2.
